order_entry_manager: RTL and testbench
======================================

Name: order_entry_manager

Overview:
Upstream stage of the order/fill matcher. Accepts order requests from the strategy and assigns monotonic 64-bit ClOrdIDs. Applies pre-trade risk checks (kill switch, qty/price bounds, outstanding-order cap, token-bucket rate limit). Emits accepted orders as a one-cycle sent pulse that feeds both the FIX encoder handshake and the matcher's order-insert port. Outstanding count is released by the matcher's order_complete pulse.

Parameters:
MAX_OUTSTANDING, 16, max live orders; matches the matcher table depth
TOKEN_MAX, 8, token-bucket capacity and reset fill level
REFILL_CYCLES, 100, clk cycles per token refill (>=2)
MAX_QTY, 10000, largest legal order quantity
PRICE_MIN, 1, lowest legal price (inclusive)
PRICE_MAX, 32'h00FFFFFF, highest legal price (inclusive)
CLORDID_BASE, 64'h1, first ClOrdID issued after reset

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
req_valid  in  1  strategy order request valid
req_ready  out  1  combinational, = (state==IDLE)
req_qty  in  32  requested quantity
req_price  in  32  requested limit price
kill_switch  in  1  level; blocks all new orders while high
tx_ready  in  1  FIX encoder can take an order this cycle
order_complete  in  1  pulse from matcher; one order retired
order_sent_valid  out  1  one-cycle pulse; order issued
sent_clordid  out  64  ClOrdID of issued order
sent_qty  out  32  qty of issued order
sent_price  out  32  price of issued order
reject_valid  out  1  one-cycle pulse; request rejected
reject_code  out  3  1 kill, 2 qty, 3 price, 4 outstanding full, 5 no token
outstanding_count  out  8  live orders
tokens  out  8  current token count
sent_count  out  32  orders issued
reject_count  out  32  requests rejected

Behaviour:
- Reset (async, rstn low): state IDLE; order_sent_valid, reject_valid, reject_code, sent_*, outstanding_count, sent_count, reject_count = 0; tokens = TOKEN_MAX; refill counter = 0; next ClOrdID = CLORDID_BASE. Reset mid-transaction drops the in-flight request silently.
- FSM IDLE -> CHECK -> (WAIT_TX | IDLE).
- IDLE: on req_valid && req_ready, latch qty/price; -> CHECK.
- CHECK, one cycle. Evaluate in priority order: kill_switch (1); qty==0 or qty>MAX_QTY (2); price<PRICE_MIN or price>PRICE_MAX (3); outstanding_count>=MAX_OUTSTANDING (4); tokens==0 (5).
  - Fail: next cycle reject_valid=1 with reject_code, reject_count+1; -> IDLE.
  - Pass: -> WAIT_TX.
- WAIT_TX:
  - kill_switch high: reject code 1; -> IDLE.
  - Else on the edge where tx_ready==1: next cycle order_sent_valid=1 with sent_clordid=current ID, sent_qty, sent_price; ID+1 (mod 2^64); tokens-1; outstanding+1; sent_count+1; -> IDLE.
  - Waits indefinitely while tx_ready==0. Outstanding and token checks are not re-evaluated.
- Latency with tx_ready=1: request accepted at edge E0; order_sent_valid high in the cycle after E2; req_ready high again in that same cycle.
- sent_* hold their last value between pulses. reject_code holds until the next reject.
- order_sent_valid and reject_valid are never both high.
- Rejects never consume a ClOrdID or a token.
- outstanding_count:
  - +1 on send; -1 on order_complete; both in the same cycle -> unchanged.
  - order_complete at 0 is ignored (saturate at 0).
- Token bucket:
  - Refill counter counts 0..REFILL_CYCLES-1 continuously; on wrap, tokens+1 saturating at TOKEN_MAX.
  - Refill and consume in the same cycle -> unchanged.
- sent_count and reject_count wrap modulo 2^32.

Test Plan:
- Reset, tx_ready=1, request qty=100 price=5000 -> order_sent_valid 3 cycles after accept, sent_clordid=1, outstanding=1, tokens=7, sent_count=1.
- Requests qty=0, then qty=10001, then price=0 -> reject_codes 2, 2, 3; reject_count=3; next valid order gets sent_clordid=1 and tokens remain 8.
- 8 back-to-back valid orders with no refill elapsed, then a 9th -> 9th rejected code 5. After 100 idle cycles a 10th order is sent with clordid=9.
- Fill outstanding to 16 with REFILL_CYCLES=2 -> 17th rejected code 4. Pulse order_complete -> outstanding=15; next order sent. order_complete in the same cycle as a send -> count unchanged.
- Order in WAIT_TX with tx_ready=0 for 20 cycles, then kill_switch=1 -> reject code 1, no order_sent_valid, ID not consumed. kill_switch held -> every request rejected code 1.
- Assert rstn low while in WAIT_TX -> all outputs at reset values, tokens=TOKEN_MAX. After release, the first order gets clordid=CLORDID_BASE.

Source files
------------

// File: rtl/order_entry_manager.sv
// Order entry front end. Assigns ClOrdIDs, runs pre-trade risk checks, rate-limits with a
// token bucket and issues accepted orders to the FIX encoder and the matcher.
module order_entry_manager #(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned TOKEN_MAX       = 8,
  parameter int unsigned REFILL_CYCLES   = 100,
  parameter int unsigned MAX_QTY         = 10000,
  parameter logic [31:0] PRICE_MIN       = 32'd1,
  parameter logic [31:0] PRICE_MAX       = 32'h00FF_FFFF,
  parameter logic [63:0] CLORDID_BASE    = 64'h1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_qty,
  input  logic [31:0] req_price,
  input  logic        kill_switch,
  input  logic        tx_ready,
  input  logic        order_complete,
  output logic        order_sent_valid,
  output logic [63:0] sent_clordid,
  output logic [31:0] sent_qty,
  output logic [31:0] sent_price,
  output logic        reject_valid,
  output logic [2:0]  reject_code,
  output logic [7:0]  outstanding_count,
  output logic [7:0]  tokens,
  output logic [31:0] sent_count,
  output logic [31:0] reject_count
);

  localparam int unsigned QTY_W    = 32;
  localparam int unsigned PRICE_W  = 32;
  localparam int unsigned ID_W     = 64;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned STAT_W   = 32;
  localparam int unsigned CODE_W   = 3;
  localparam int unsigned REFILL_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

  localparam logic [CODE_W-1:0] RC_KILL   = CODE_W'(1);
  localparam logic [CODE_W-1:0] RC_QTY    = CODE_W'(2);
  localparam logic [CODE_W-1:0] RC_PRICE  = CODE_W'(3);
  localparam logic [CODE_W-1:0] RC_FULL   = CODE_W'(4);
  localparam logic [CODE_W-1:0] RC_NO_TOK = CODE_W'(5);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WAIT_TX
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [QTY_W-1:0]     qty_q;
  logic [PRICE_W-1:0]   price_q;
  logic [ID_W-1:0]      next_id_q;
  logic [REFILL_W-1:0]  refill_q;
  logic                 accept_c;
  logic                 send_fire_c;
  logic                 rej_fire_c;
  logic [CODE_W-1:0]    rej_code_c;
  logic                 refill_wrap_c;

  assign req_ready     = (state_q == IDLE);
  assign refill_wrap_c = (refill_q == REFILL_W'(REFILL_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and one-cycle decision strobes; risk checks in priority order
  always_comb begin
    state_d     = state_q;
    accept_c    = 1'b0;
    send_fire_c = 1'b0;
    rej_code_c  = '0;
    rej_fire_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (kill_switch)                                     rej_code_c = RC_KILL;
        else if (qty_q == '0 || qty_q > QTY_W'(MAX_QTY))     rej_code_c = RC_QTY;
        else if (price_q < PRICE_MIN || price_q > PRICE_MAX) rej_code_c = RC_PRICE;
        else if (outstanding_count >= CNT_W'(MAX_OUTSTANDING)) rej_code_c = RC_FULL;
        else if (tokens == '0)                               rej_code_c = RC_NO_TOK;
        rej_fire_c = (rej_code_c != '0);
        state_d    = rej_fire_c ? IDLE : WAIT_TX;
      end
      WAIT_TX: begin
        if (kill_switch) begin
          rej_fire_c = 1'b1;
          rej_code_c = RC_KILL;
          state_d    = IDLE;
        end else if (tx_ready) begin
          send_fire_c = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, issue/reject pulses and statistics
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      qty_q            <= '0;
      price_q          <= '0;
      next_id_q        <= CLORDID_BASE;
      order_sent_valid <= 1'b0;
      sent_clordid     <= '0;
      sent_qty         <= '0;
      sent_price       <= '0;
      reject_valid     <= 1'b0;
      reject_code      <= '0;
      sent_count       <= '0;
      reject_count     <= '0;
    end else begin
      order_sent_valid <= send_fire_c;
      reject_valid     <= rej_fire_c;
      if (accept_c) begin
        qty_q   <= req_qty;
        price_q <= req_price;
      end
      if (send_fire_c) begin
        sent_clordid <= next_id_q;
        sent_qty     <= qty_q;
        sent_price   <= price_q;
        next_id_q    <= next_id_q + ID_W'(1);
        sent_count   <= sent_count + STAT_W'(1);
      end
      if (rej_fire_c) begin
        reject_code  <= rej_code_c;
        reject_count <= reject_count + STAT_W'(1);
      end
    end
  end

  // Token bucket: free-running refill counter, a send and a refill in one cycle cancel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      refill_q <= '0;
      tokens   <= CNT_W'(TOKEN_MAX);
    end else begin
      refill_q <= refill_wrap_c ? '0 : refill_q + REFILL_W'(1);
      if (send_fire_c && !refill_wrap_c)
        tokens <= tokens - CNT_W'(1);
      else if (refill_wrap_c && !send_fire_c && tokens < CNT_W'(TOKEN_MAX))
        tokens <= tokens + CNT_W'(1);
    end
  end

  // Live-order count; a retire at zero is ignored
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding_count <= '0;
    end else if (send_fire_c && !order_complete) begin
      outstanding_count <= outstanding_count + CNT_W'(1);
    end else if (order_complete && !send_fire_c && outstanding_count != '0) begin
      outstanding_count <= outstanding_count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_order_entry_manager.sv
// Scoreboard bench for order_entry_manager: directed scenarios plus randomized orders checked
// against a transaction-level risk/token/outstanding model.
module tb_order_entry_manager;

  localparam int unsigned MAX_OUT = 16;
  localparam int unsigned TOK_MAX = 8;
  localparam int unsigned REFILL  = 100;
  localparam int unsigned MAXQ    = 10000;
  localparam logic [31:0] PMIN    = 32'd1;
  localparam logic [31:0] PMAX    = 32'h00FF_FFFF;
  localparam logic [63:0] ID_BASE = 64'h1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_qty = '0;
  logic [31:0] req_price = '0;
  logic        kill_switch = 1'b0;
  logic        tx_ready = 1'b0;
  logic        order_complete = 1'b0;
  logic        order_sent_valid;
  logic [63:0] sent_clordid;
  logic [31:0] sent_qty;
  logic [31:0] sent_price;
  logic        reject_valid;
  logic [2:0]  reject_code;
  logic [7:0]  outstanding_count;
  logic [7:0]  tokens;
  logic [31:0] sent_count;
  logic [31:0] reject_count;

  always #5 clk = ~clk;

  order_entry_manager #(
    .MAX_OUTSTANDING(MAX_OUT), .TOKEN_MAX(TOK_MAX), .REFILL_CYCLES(REFILL), .MAX_QTY(MAXQ),
    .PRICE_MIN(PMIN), .PRICE_MAX(PMAX), .CLORDID_BASE(ID_BASE)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_qty(req_qty), .req_price(req_price), .kill_switch(kill_switch),
    .tx_ready(tx_ready), .order_complete(order_complete),
    .order_sent_valid(order_sent_valid), .sent_clordid(sent_clordid),
    .sent_qty(sent_qty), .sent_price(sent_price), .reject_valid(reject_valid),
    .reject_code(reject_code), .outstanding_count(outstanding_count), .tokens(tokens),
    .sent_count(sent_count), .reject_count(reject_count)
  );

  typedef struct {
    bit          is_send;
    logic [63:0] id;
    logic [31:0] qty;
    logic [31:0] price;
    logic [2:0]  code;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          m_tokens = TOK_MAX;
  int          m_out = 0;
  int          m_refill = 0;
  bit          m_wrap;
  bit          m_send = 1'b0;
  logic [63:0] m_id = ID_BASE;
  logic [31:0] m_sent = '0;
  logic [31:0] m_rej = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference resources: refill every REFILL cycles, send consumes a token and adds a live order
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_tokens = TOK_MAX;
      m_out    = 0;
      m_refill = 0;
    end else begin
      m_wrap   = (m_refill == REFILL - 1);
      m_refill = m_wrap ? 0 : m_refill + 1;
      if (m_send && !m_wrap) m_tokens = m_tokens - 1;
      else if (m_wrap && !m_send && m_tokens < TOK_MAX) m_tokens = m_tokens + 1;
      if (m_send && !order_complete) m_out = m_out + 1;
      else if (order_complete && !m_send && m_out > 0) m_out = m_out - 1;
    end
  end

  // Monitor: resource levels every cycle, pulses popped against the scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      chk("tokens", 64'(tokens), 64'(m_tokens));
      chk("outstanding", 64'(outstanding_count), 64'(m_out));
      if (order_sent_valid || reject_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {62'd0, order_sent_valid, reject_valid}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_send) begin
            chk("sent_valid", 64'(order_sent_valid), 64'd1);
            chk("sent_excl_reject", 64'(reject_valid), 64'd0);
            chk("sent_clordid", sent_clordid, mon_e.id);
            chk("sent_qty", 64'(sent_qty), 64'(mon_e.qty));
            chk("sent_price", 64'(sent_price), 64'(mon_e.price));
            chk("sent_count", 64'(sent_count), 64'(mon_e.cnt));
          end else begin
            chk("reject_valid", 64'(reject_valid), 64'd1);
            chk("reject_excl_sent", 64'(order_sent_valid), 64'd0);
            chk("reject_code", 64'(reject_code), 64'(mon_e.code));
            chk("reject_count", 64'(reject_count), 64'(mon_e.cnt));
          end
        end
      end
    end
  end

  task automatic push_rej(input logic [2:0] code);
    exp_t e;
    m_rej     = m_rej + 32'd1;
    e.is_send = 1'b0;
    e.id      = '0;
    e.qty     = '0;
    e.price   = '0;
    e.code    = code;
    e.cnt     = m_rej;
    exp_q.push_back(e);
  endtask

  task automatic push_send(input logic [31:0] q, input logic [31:0] p);
    exp_t e;
    m_sent    = m_sent + 32'd1;
    e.is_send = 1'b1;
    e.id      = m_id;
    e.qty     = q;
    e.price   = p;
    e.code    = '0;
    e.cnt     = m_sent;
    m_id      = m_id + 64'd1;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = 1'b0; tx_ready = 1'b0; kill_switch = 1'b0; order_complete = 1'b0;
    m_send = 1'b0; m_id = ID_BASE; m_sent = '0; m_rej = '0;
    exp_q.delete();
    #1;
    chk("rst_sent_valid", 64'(order_sent_valid), 64'd0);
    chk("rst_reject_valid", 64'(reject_valid), 64'd0);
    chk("rst_reject_code", 64'(reject_code), 64'd0);
    chk("rst_sent_clordid", sent_clordid, 64'd0);
    chk("rst_sent_qty", 64'(sent_qty), 64'd0);
    chk("rst_sent_price", 64'(sent_price), 64'd0);
    chk("rst_outstanding", 64'(outstanding_count), 64'd0);
    chk("rst_tokens", 64'(tokens), 64'(TOK_MAX));
    chk("rst_sent_count", 64'(sent_count), 64'd0);
    chk("rst_reject_count", 64'(reject_count), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // One request from an idle DUT; returns on the negedge where its outcome pulse is visible
  task automatic do_order(input logic [31:0] q, input logic [31:0] p, input int tx_wait,
                          input int kill_wait, input bit comp_with_send);
    logic [2:0] code;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_qty = q; req_price = p;
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    code = 3'd0;
    if (kill_switch)                 code = 3'd1;
    else if (q == 0 || q > MAXQ)     code = 3'd2;
    else if (p < PMIN || p > PMAX)   code = 3'd3;
    else if (m_out >= MAX_OUT)       code = 3'd4;
    else if (m_tokens == 0)          code = 3'd5;
    if (code != 3'd0) begin
      push_rej(code);
      @(negedge clk);
    end else begin
      @(negedge clk);
      for (int cyc = 0; cyc <= tx_wait; cyc++) begin
        if (kill_wait >= 0 && cyc >= kill_wait) begin
          kill_switch = 1'b1;
          push_rej(3'd1);
          @(negedge clk);
          kill_switch = 1'b0;
          break;
        end
        if (cyc >= tx_wait) begin
          tx_ready = 1'b1; m_send = 1'b1; order_complete = comp_with_send;
          push_send(q, p);
          @(negedge clk);
          tx_ready = 1'b0; m_send = 1'b0; order_complete = 1'b0;
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_token();
    for (int g = 0; g < 300 && m_tokens == 0; g++) @(negedge clk);
  endtask

  task automatic pulse_complete();
    order_complete = 1'b1;
    @(negedge clk);
    order_complete = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // Single order with tx_ready already high
    do_reset();
    do_order(32'd100, 32'd5000, 0, -1, 1'b0);
    chk("t1_sent_valid", 64'(order_sent_valid), 64'd1);
    chk("t1_clordid", sent_clordid, 64'd1);
    chk("t1_outstanding", 64'(outstanding_count), 64'd1);
    chk("t1_tokens", 64'(tokens), 64'd7);
    chk("t1_sent_count", 64'(sent_count), 64'd1);

    // Bound rejects consume neither ID nor token
    do_reset();
    do_order(32'd0, 32'd5000, 0, -1, 1'b0);
    do_order(32'd10001, 32'd5000, 0, -1, 1'b0);
    do_order(32'd100, 32'd0, 0, -1, 1'b0);
    chk("t2_code", 64'(reject_code), 64'd3);
    chk("t2_reject_count", 64'(reject_count), 64'd3);
    chk("t2_tokens", 64'(tokens), 64'd8);
    do_order(32'd100, 32'd5000, 0, -1, 1'b0);
    chk("t2_clordid", sent_clordid, 64'd1);

    // Token exhaustion then one refill
    do_reset();
    for (int i = 0; i < 8; i++) do_order(32'd10 + 32'(i), 32'd1000, 0, -1, 1'b0);
    chk("t3_tokens_empty", 64'(tokens), 64'd0);
    do_order(32'd10, 32'd1000, 0, -1, 1'b0);
    chk("t3_code5", 64'(reject_code), 64'd5);
    repeat (100) @(negedge clk);
    do_order(32'd10, 32'd1000, 0, -1, 1'b0);
    chk("t3_clordid", sent_clordid, 64'd9);

    // Outstanding cap, release, and simultaneous send/complete
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wait_token();
      do_order(32'd50, 32'd1000, 0, -1, 1'b0);
    end
    chk("t4_full", 64'(outstanding_count), 64'd16);
    wait_token();
    do_order(32'd50, 32'd1000, 0, -1, 1'b0);
    chk("t4_code4", 64'(reject_code), 64'd4);
    pulse_complete();
    chk("t4_released", 64'(outstanding_count), 64'd15);
    wait_token();
    do_order(32'd50, 32'd1000, 0, -1, 1'b0);
    chk("t4_sent_after_release", 64'(order_sent_valid), 64'd1);
    pulse_complete();
    wait_token();
    do_order(32'd51, 32'd1001, 0, -1, 1'b1);
    chk("t4_same_cycle", 64'(outstanding_count), 64'd15);

    // Kill while waiting on tx_ready, then kill held
    do_reset();
    do_order(32'd100, 32'd5000, 1000, 20, 1'b0);
    chk("t5_kill_code", 64'(reject_code), 64'd1);
    chk("t5_no_send", 64'(order_sent_valid), 64'd0);
    do_order(32'd100, 32'd5000, 0, -1, 1'b0);
    chk("t5_clordid", sent_clordid, 64'd1);
    kill_switch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_order(32'd100, 32'd5000, 0, -1, 1'b0);
      chk("t5_held_code", 64'(reject_code), 64'd1);
    end
    kill_switch = 1'b0;

    // Reset while an order sits in WAIT_TX
    do_reset();
    do_order(32'd100, 32'd5000, 0, -1, 1'b0);
    do_order(32'd0, 32'd5000, 0, -1, 1'b0);
    req_valid = 1'b1; req_qty = 32'd200; req_price = 32'd7000;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    do_reset();
    do_order(32'd300, 32'd9000, 0, -1, 1'b0);
    chk("t6_clordid", sent_clordid, ID_BASE);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] q;
      logic [31:0] p;
      int          sel;
      int          txw;
      int          kw;
      sel = int'($urandom_range(0, 9));
      q = (sel == 0) ? 32'd0 : (sel == 1) ? 32'd10001 + 32'($urandom_range(0, 1000))
                                          : 32'($urandom_range(1, MAXQ));
      sel = int'($urandom_range(0, 9));
      p = (sel == 0) ? 32'd0 : (sel == 1) ? PMAX + 32'd1 + 32'($urandom_range(0, 100)) :
          (sel == 2) ? PMAX : (sel == 3) ? PMIN : 32'($urandom_range(1, PMAX));
      txw = int'($urandom_range(0, 3));
      kw  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, txw)) : -1;
      kill_switch = ($urandom_range(0, 15) == 0);
      do_order(q, p, txw, kw, $urandom_range(0, 3) == 0);
      kill_switch = 1'b0;
      repeat ($urandom_range(0, 40)) begin
        order_complete = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      order_complete = 1'b0;
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
